key_latch_ctrl: RTL and testbench

KEY_LATCH_CTRL -- requirements
Module: key_latch_ctrl

---
 rtl/key_latch_ctrl_if.sv | 29 ++
 rtl/key_latch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_key_latch_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/key_latch_ctrl_if.sv
// Handshake/bus bundle between key_latch_ctrl, the pad latch bank,
// the debouncers and the event consumer.
interface key_latch_ctrl_if #(
  parameter int NUM_PADS = 4
);
  localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  logic [NUM_PADS-1:0] press;
  logic [NUM_PADS-1:0] ff_q;
  logic [NUM_PADS-1:0] ff_pre;
  logic [NUM_PADS-1:0] ff_clr;
  logic                evt_valid;
  logic                evt_ready;
  logic [IDX_W-1:0]    evt_pad;
  logic                busy;
  logic                drop;

  // controller side
  modport master (
    input  press, ff_q, evt_ready,
    output ff_pre, ff_clr, evt_valid, evt_pad, busy, drop
  );

  // bank / debouncer / consumer side
  modport slave (
    output press, ff_q, evt_ready,
    input  ff_pre, ff_clr, evt_valid, evt_pad, busy, drop
  );
endinterface

// File: rtl/key_latch_ctrl.sv
// key_latch_ctrl: sets/clears a bank of asynchronous pad latches and
// offers latched pad presses one at a time as valid/ready events,
// scanning round-robin from a rotating pointer.
// Optional macro KEY_LATCH_TIMEOUT_EN: an event not accepted within
// TIMEOUT cycles is discarded (drop pulse) and its latch is cleared.
module key_latch_ctrl #(
  parameter int NUM_PADS  = 4,
  parameter int CLR_PULSE = 2,
  parameter int TIMEOUT   = 255
) (
  input logic C,
  input logic CLR,
  key_latch_ctrl_if.master bus
);
  localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  localparam logic [2:0] INIT    = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] PRESENT = 3'd2;
  localparam logic [2:0] CLEAR   = 3'd3;
  localparam logic [2:0] SETTLE  = 3'd4;

  logic [2:0]          state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [3:0]          cnt, cnt_n;
  logic [NUM_PADS-1:0] pend, pend_n;
  logic [NUM_PADS-1:0] pre_q, pre_n;
  logic [NUM_PADS-1:0] clr_q, clr_n;
  logic                vld_q, vld_n;
  logic [IDX_W-1:0]    pad_q, pad_n;
  logic                busy_q;
  logic [IDX_W-1:0]    sel;
  logic                found;
  logic [NUM_PADS-1:0] idx_oh;
  logic [NUM_PADS-1:0] want;
`ifdef KEY_LATCH_TIMEOUT_EN
  logic [7:0]          tmo, tmo_n;
  logic                drop_q, drop_n;
`endif

  assign idx_oh = NUM_PADS'(1) << idx;

  // round-robin pick: first latched pad at or after ptr, wrapping
  always_comb begin
    int j;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_PADS; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_PADS) j = j - NUM_PADS;
      if (!found && bus.ff_q[j]) begin
        sel   = IDX_W'(j);
        found = 1'b1;
      end
    end
  end

  // next-state and next-output decode; all outputs are registered
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    cnt_n   = cnt;
    clr_n   = '0;
    vld_n   = vld_q;
    pad_n   = pad_q;
`ifdef KEY_LATCH_TIMEOUT_EN
    tmo_n   = tmo;
    drop_n  = 1'b0;
`endif
    case (state)
      INIT: begin
        if (cnt == 4'(CLR_PULSE)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          clr_n = '1;
          cnt_n = cnt + 4'd1;
        end
      end
      IDLE: begin
        if (found) begin
          idx_n   = sel;
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (!vld_q) begin
          // offer one cycle after the pick so evt_pad is a clean register
          vld_n = 1'b1;
          pad_n = idx;
`ifdef KEY_LATCH_TIMEOUT_EN
          tmo_n = '0;
`endif
        end else if (bus.evt_ready) begin
          vld_n   = 1'b0;
          clr_n   = idx_oh;
          cnt_n   = 4'd1;
          state_n = CLEAR;
        end
`ifdef KEY_LATCH_TIMEOUT_EN
        else if (tmo == 8'(TIMEOUT - 1)) begin
          // consumer never took it: discard and clear the latch anyway
          vld_n   = 1'b0;
          drop_n  = 1'b1;
          clr_n   = idx_oh;
          cnt_n   = 4'd1;
          state_n = CLEAR;
        end else begin
          tmo_n = tmo + 8'd1;
        end
`endif
      end
      CLEAR: begin
        if (cnt == 4'(CLR_PULSE)) begin
          cnt_n   = '0;
          state_n = SETTLE;
        end else begin
          clr_n = idx_oh;
          cnt_n = cnt + 4'd1;
        end
      end
      SETTLE: begin
        ptr_n   = (idx == IDX_W'(NUM_PADS - 1)) ? '0 : idx + 1'b1;
        state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  // a press on a pad whose CLR is driven next cycle waits in pend until
  // CLR falls, so PRE and CLR never overlap on one latch
  always_comb begin
    want   = bus.press | pend;
    pre_n  = want & ~clr_n;
    pend_n = want & clr_n;
  end

  // state and output registers
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state  <= INIT;
      ptr    <= '0;
      idx    <= '0;
      cnt    <= '0;
      pend   <= '0;
      pre_q  <= '0;
      clr_q  <= '0;
      vld_q  <= 1'b0;
      pad_q  <= '0;
      busy_q <= 1'b1;
`ifdef KEY_LATCH_TIMEOUT_EN
      tmo    <= '0;
      drop_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      pend   <= pend_n;
      pre_q  <= pre_n;
      clr_q  <= clr_n;
      vld_q  <= vld_n;
      pad_q  <= pad_n;
      busy_q <= (state_n != IDLE);
`ifdef KEY_LATCH_TIMEOUT_EN
      tmo    <= tmo_n;
      drop_q <= drop_n;
`endif
    end
  end

  assign bus.ff_pre    = pre_q;
  assign bus.ff_clr    = clr_q;
  assign bus.evt_valid = vld_q;
  assign bus.evt_pad   = pad_q;
  assign bus.busy      = busy_q;
`ifdef KEY_LATCH_TIMEOUT_EN
  assign bus.drop      = drop_q;
`else
  assign bus.drop      = 1'b0;
`endif
endmodule

// File: tb/tb_key_latch_ctrl.sv
// Directed bench for key_latch_ctrl with a behavioural latch bank and
// an event scoreboard (expected pads queued at press time).
module tb_key_latch_ctrl;
  localparam int NP = 4;

  logic C;
  logic CLR;
  int   tests = 0;
  int   fails = 0;
  int   overlap = 0;
  int   n;
  logic [NP-1:0] bank = '0;
  logic [1:0] sb[$];

  key_latch_ctrl_if #(.NUM_PADS(NP)) bus ();

  key_latch_ctrl #(.NUM_PADS(NP), .CLR_PULSE(2), .TIMEOUT(5)) dut (
    .C   (C),
    .CLR (CLR),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // latch bank model: PRE sets, CLR clears
  always @(posedge C) begin
    for (int i = 0; i < NP; i++) begin
      if (bus.ff_pre[i])      bank[i] <= 1'b1;
      else if (bus.ff_clr[i]) bank[i] <= 1'b0;
    end
  end
  assign bus.ff_q = bank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && bus.evt_valid !== 1'b1; i++) step();
    check(tag, bus.evt_valid, 1'b1);
  endtask

  // scoreboard: every accepted event must match the next queued pad
  always @(negedge C) begin
    if (!CLR && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
      check("evt_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) check("evt_pad", bus.evt_pad, sb.pop_front());
    end
    if ((bus.ff_pre & bus.ff_clr) != '0) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    CLR = 1'b0;
    bus.press = '0;
    bus.evt_ready = 1'b0;
    #1 CLR = 1'b1;
    #1;
    check("rst_clr", bus.ff_clr, 4'h0);
    check("rst_pre", bus.ff_pre, 4'h0);
    check("rst_valid", bus.evt_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_drop", bus.drop, 1'b0);
    step(); step();
    check("rst_hold_clr", bus.ff_clr, 4'h0);
    CLR = 1'b0;
    step(); check("init_clr1", bus.ff_clr, 4'hF); check("init_busy", bus.busy, 1'b1);
    step(); check("init_clr2", bus.ff_clr, 4'hF);
    step(); check("init_done_clr", bus.ff_clr, 4'h0); check("idle_busy", bus.busy, 1'b0);

    // single press on pad 2, exact latency through the whole cycle
    bus.evt_ready = 1'b1;
    bus.press = 4'b0100; sb.push_back(2'd2);
    step(); bus.press = '0;
    check("pre_pulse", bus.ff_pre, 4'b0100);
    step(); check("pre_one_cycle", bus.ff_pre, 4'b0000); check("no_valid_e2", bus.evt_valid, 1'b0);
    step(); check("no_valid_e3", bus.evt_valid, 1'b0); check("busy_present", bus.busy, 1'b1);
    step(); check("valid_e4", bus.evt_valid, 1'b1); check("pad_e4", bus.evt_pad, 2'd2);
    step(); check("clr_a", bus.ff_clr, 4'b0100); check("valid_dropped", bus.evt_valid, 1'b0);
    step(); check("clr_b", bus.ff_clr, 4'b0100);
    step(); check("clr_end", bus.ff_clr, 4'b0000); check("settle_busy", bus.busy, 1'b1);
    step(); check("back_idle", bus.busy, 1'b0);

    // ptr now 3: pads 3 and 0 latched -> pad 3 first, then wrap to pad 0
    bus.press = 4'b1001; sb.push_back(2'd3); sb.push_back(2'd0);
    step(); bus.press = '0;
    check("pre_multi", bus.ff_pre, 4'b1001);
    repeat (25) step();
    check("wrap_sb_empty", sb.size(), 0);
    check("wrap_idle", bus.busy, 1'b0);

    // press on pad 1 while pad 1 is being cleared is deferred
    bus.press = 4'b0010; sb.push_back(2'd1);
    step(); bus.press = '0;
    for (int i = 0; i < 30 && bus.ff_clr[1] !== 1'b1; i++) step();
    check("clr1_seen", bus.ff_clr[1], 1'b1);
    bus.press = 4'b0010; sb.push_back(2'd1);
    step(); bus.press = '0;
    check("defer_pre_low", bus.ff_pre[1], 1'b0);
    check("defer_clr_high", bus.ff_clr[1], 1'b1);
    step(); check("defer_pre_issued", bus.ff_pre, 4'b0010); check("defer_clr_low", bus.ff_clr, 4'b0000);
    step(); check("defer_pre_one", bus.ff_pre, 4'b0000);
    repeat (25) step();
    check("defer_sb_empty", sb.size(), 0);

    // consumer stalls on pad 0; another pad pressed meanwhile
    bus.evt_ready = 1'b0;
    bus.press = 4'b0001;
`ifndef KEY_LATCH_TIMEOUT_EN
    sb.push_back(2'd0);
`endif
    step(); bus.press = '0;
    wait_valid("stall_valid");
    check("stall_pad", bus.evt_pad, 2'd0);
    bus.press = 4'b0100; sb.push_back(2'd2);
    step(); bus.press = '0;
    check("other_pre", bus.ff_pre, 4'b0100);
    check("stall_hold_valid", bus.evt_valid, 1'b1);
    check("stall_hold_pad", bus.evt_pad, 2'd0);
    n = 2;
`ifdef KEY_LATCH_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.evt_valid === 1'b1) n++;
      else break;
    end
    check("tmo_valid_cycles", n, 5);
    check("tmo_drop", bus.drop, 1'b1);
    check("tmo_clr", bus.ff_clr, 4'b0001);
    step(); check("tmo_drop_once", bus.drop, 1'b0); check("tmo_clr2", bus.ff_clr, 4'b0001);
`else
    repeat (20) step();
    check("notmo_valid", bus.evt_valid, 1'b1);
    check("notmo_pad", bus.evt_pad, 2'd0);
    check("notmo_drop", bus.drop, 1'b0);
`endif
    bus.evt_ready = 1'b1;
    repeat (30) step();
    check("stall_sb_empty", sb.size(), 0);
    check("stall_idle", bus.busy, 1'b0);

    // reset while an event is offered: aborted, never re-offered
    bus.evt_ready = 1'b0;
    bus.press = 4'b0001;
    step(); bus.press = '0;
    wait_valid("abort_valid");
    #2 CLR = 1'b1;
    #1;
    check("abort_valid_low", bus.evt_valid, 1'b0);
    check("abort_busy", bus.busy, 1'b1);
    check("abort_pre", bus.ff_pre, 4'h0);
    step(); step();
    CLR = 1'b0;
    bus.evt_ready = 1'b1;
    step(); check("reinit_clr1", bus.ff_clr, 4'hF);
    step(); check("reinit_clr2", bus.ff_clr, 4'hF);
    step(); check("reinit_done", bus.ff_clr, 4'h0);
    repeat (20) step();
    check("abort_no_event", bus.evt_valid, 1'b0);
    check("abort_sb_empty", sb.size(), 0);
    check("never_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
